rs232_mem_burst: RTL
====================

# rs232_mem_burst

Parametrised successor to the RS232 memory macro. It pairs a single-port synchronous RAM with a burst engine. A command handshake starts a read or write burst of up to 2^LEN_W beats, with the address auto-incrementing and wrapping. Write and read data use valid/ready streams with backpressure. The block sits between the RS232 command decoder and storage, and an optional post-reset sweep zeroes the array.

## Interface
- DATA_W, 8, data width in bits
- ADDR_W, 14, address width
- DEPTH, 16384, words stored; 2 ≤ DEPTH ≤ 2^ADDR_W
- LEN_W, 8, burst-length field width
- CLEAR_ON_RST, 1, 1 = zero every word after reset
- clk  in  1  rising-edge clock, single domain
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted this cycle when both high
- cmd_write  in  1  1 = write burst, 0 = read burst
- cmd_addr  in  ADDR_W  start address
- cmd_len  in  LEN_W  beats minus one
- wr_data  in  DATA_W  write beat data
- wr_valid  in  1  write beat offered
- wr_ready  out  1  write beat taken when both high
- rd_data  out  DATA_W  read beat data
- rd_valid  out  1  read beat offered
- rd_ready  in  1  read beat consumed when both high
- busy  out  1  high in any state except IDLE
- err  out  1  one-cycle pulse on an out-of-range command

## Operation
- States: CLEAR, IDLE, WRITE, READ.
- Reset exits to CLEAR if CLEAR_ON_RST=1, otherwise to IDLE.
- CLEAR: writes 0 to addresses 0..DEPTH-1, one per cycle, then goes to IDLE. cmd_ready=0 throughout.
- IDLE: cmd_ready=1. On the handshake, latch addr, latch remaining = cmd_len+1, and go to WRITE or READ.
- Out-of-range command (cmd_addr ≥ DEPTH): accepted, err=1 for the next cycle, no memory access, no beats, stay in IDLE.
- WRITE: wr_ready=1. Each wr handshake writes wr_data to addr, increments addr, and decrements remaining. After the last beat, go to IDLE.
- READ: a read is issued when remaining>0 and (!rd_valid || rd_ready).
  - An issue loads the RAM output register, which is rd_data, sets rd_valid, increments addr, and decrements remaining.
  - A consume with no issue clears rd_valid.
  - When remaining==0 and the final beat is consumed, go to IDLE.
- Address arithmetic is modulo DEPTH: DEPTH-1 wraps to 0, including for non-power-of-two DEPTH.
- cmd_valid outside IDLE is ignored. wr_valid outside WRITE is ignored, and memory is unchanged.
- rd_data holds stable while rd_valid=1 and rd_ready=0.

## Timing
- Reset values, after the first edge with rst=1: cmd_ready=0, wr_ready=0, rd_valid=0, rd_data=0, err=0, busy=0.
- First cycle after rst falls:
  - With CLEAR: busy=1, cmd_ready=0.
  - Without CLEAR: cmd_ready=1, busy=0.
- Clear duration is exactly DEPTH cycles. cmd_ready rises in cycle DEPTH+1 after rst falls.
- Read latency: handshake at edge T, first issue at edge T+1, rd_valid=1 after T+1. rd_ready held high gives one beat per cycle.
- Write throughput is one beat per cycle.
- A burst of N beats with no stalls returns cmd_ready after N+1 cycles for writes and N+2 cycles for reads.
- A read after a write to the same address returns the new data, since bursts never overlap.
- rst mid-burst aborts at the next edge:
  - Remaining beats are discarded and rd_valid drops.
  - Words already written keep their values unless the clear sweep runs.
  - The clear sweep restarts from address 0.

## Structure
- Package rs232_mem_pkg holds the state enum (CLEAR/IDLE/WRITE/READ) and default parameter constants.
- Sub-module rs232_mem_array: single-port synchronous RAM, DATA_W×DEPTH, with write enable and a read-enable-gated registered output.
- The burst FSM, address counter and beat counter live in rs232_mem_burst.

## Test plan
- Reset with CLEAR_ON_RST=1, DEPTH=16 -> busy for exactly 16 cycles, then cmd_ready=1; a 16-beat read from address 0 returns all 0x00.
- Write burst addr=3, len=3, data 0x11..0x14, then read addr=3, len=3 with rd_ready=1 -> 0x11,0x12,0x13,0x14 on consecutive cycles, first rd_valid two edges after the read command.
- DEPTH=10, write addr=8, len=3 with data A0..A3 -> words 8,9,0,1 hold A0,A1,A2,A3; reading back 8..1 matches.
- Read len=4 with rd_ready toggling 1,0,0,1,... -> rd_data holds during stalls; 5 beats delivered in order, none lost or duplicated.
- cmd_addr=DEPTH -> err pulses one cycle, no rd_valid, cmd_ready stays 1; memory contents unchanged.
- rst asserted after 2 of 6 write beats -> rd_valid and wr_ready low next cycle, clear sweep restarts; afterwards all reads return 0.

Source files
------------

// File: rtl/rs232_mem_pkg.sv
// Shared types and default sizing for the RS232 burst memory block.
package rs232_mem_pkg;

  typedef enum logic [1:0] {
    ST_CLEAR,
    ST_IDLE,
    ST_WRITE,
    ST_READ
  } state_t;

  localparam int DEF_DATA_W       = 8;
  localparam int DEF_ADDR_W       = 14;
  localparam int DEF_DEPTH        = 16384;
  localparam int DEF_LEN_W        = 8;
  localparam int DEF_CLEAR_ON_RST = 1;

endpackage

// File: rtl/rs232_mem_burst_if.sv
// Command, write-stream and read-stream signals between the RS232 decoder and the burst memory.
interface rs232_mem_burst_if
  import rs232_mem_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int LEN_W  = DEF_LEN_W
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [LEN_W-1:0]  cmd_len;
  logic [DATA_W-1:0] wr_data;
  logic              wr_valid;
  logic              wr_ready;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              rd_ready;
  logic              busy;
  logic              err;

  modport master (
    output cmd_valid, cmd_write, cmd_addr, cmd_len, wr_data, wr_valid, rd_ready,
    input  cmd_ready, wr_ready, rd_data, rd_valid, busy, err
  );

  modport slave (
    input  cmd_valid, cmd_write, cmd_addr, cmd_len, wr_data, wr_valid, rd_ready,
    output cmd_ready, wr_ready, rd_data, rd_valid, busy, err
  );
endinterface

// File: rtl/rs232_mem_array.sv
// Single-port synchronous RAM; the read register only loads when i_re is high, so it holds under stall.
module rs232_mem_array
  import rs232_mem_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_we,
  input  logic              i_re,
  input  logic [IDX_W-1:0]  i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
  end

  always_ff @(posedge clk) begin
    if (rst)       r_rdata <= '0;
    else if (i_re) r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/rs232_mem_burst.sv
// Burst engine over rs232_mem_array: command handshake, wrapping address counter, beat counter,
// optional post-reset zero sweep.
module rs232_mem_burst
  import rs232_mem_pkg::*;
#(
  parameter int DATA_W       = DEF_DATA_W,
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DEPTH        = DEF_DEPTH,
  parameter int LEN_W        = DEF_LEN_W,
  parameter int CLEAR_ON_RST = DEF_CLEAR_ON_RST
) (
  input  logic               clk,
  input  logic               rst,
  rs232_mem_burst_if.slave   bus
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int REM_W = LEN_W + 1;
  localparam logic [IDX_W-1:0] LAST    = IDX_W'(DEPTH - 1);
  localparam logic [REM_W-1:0] REM_ONE = REM_W'(1);
  localparam logic [31:0]      DEPTH_U = 32'(DEPTH);

  function automatic logic [IDX_W-1:0] next_addr(input logic [IDX_W-1:0] a);
    return (a == LAST) ? '0 : a + 1'b1;
  endfunction

  state_t             r_state;
  logic [IDX_W-1:0]   r_addr;
  logic [REM_W-1:0]   r_remain;
  logic               r_cmd_ready;
  logic               r_wr_ready;
  logic               r_rd_valid;
  logic               r_busy;
  logic               r_err;

  logic               w_cmd_fire;
  logic               w_in_range;
  logic               w_wr_fire;
  logic               w_issue;
  logic               w_consume;
  logic               w_clear_we;
  logic               w_we;
  logic [DATA_W-1:0]  w_wdata;
  logic [DATA_W-1:0]  w_rdata;

  assign w_cmd_fire = bus.cmd_valid && r_cmd_ready;
  assign w_in_range = 32'(bus.cmd_addr) < DEPTH_U;
  assign w_wr_fire  = bus.wr_valid && r_wr_ready;
  assign w_issue    = (r_state == ST_READ) && (r_remain != '0) && (!r_rd_valid || bus.rd_ready);
  assign w_consume  = r_rd_valid && bus.rd_ready;
  // The first cycle in CLEAR only raises busy; the sweep writes during the following DEPTH cycles.
  assign w_clear_we = (r_state == ST_CLEAR) && r_busy;
  assign w_we       = (w_clear_we || w_wr_fire) && !rst;
  assign w_wdata    = w_clear_we ? '0 : bus.wr_data;

  rs232_mem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_we),
    .i_re    (w_issue && !rst),
    .i_addr  (r_addr),
    .i_wdata (w_wdata),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= (CLEAR_ON_RST != 0) ? ST_CLEAR : ST_IDLE;
      r_addr      <= '0;
      r_remain    <= '0;
      r_cmd_ready <= 1'b0;
      r_wr_ready  <= 1'b0;
      r_rd_valid  <= 1'b0;
      r_busy      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        ST_CLEAR: begin
          r_busy <= 1'b1;
          if (r_busy) begin
            r_addr <= next_addr(r_addr);
            if (r_addr == LAST) begin
              r_state     <= ST_IDLE;
              r_busy      <= 1'b0;
              r_cmd_ready <= 1'b1;
            end
          end
        end
        ST_IDLE: begin
          r_cmd_ready <= 1'b1;
          r_busy      <= 1'b0;
          if (w_cmd_fire) begin
            if (!w_in_range) begin
              r_err <= 1'b1;
            end else begin
              r_addr      <= bus.cmd_addr[IDX_W-1:0];
              r_remain    <= {1'b0, bus.cmd_len} + REM_ONE;
              r_cmd_ready <= 1'b0;
              r_busy      <= 1'b1;
              if (bus.cmd_write) begin
                r_state    <= ST_WRITE;
                r_wr_ready <= 1'b1;
              end else begin
                r_state    <= ST_READ;
              end
            end
          end
        end
        ST_WRITE: begin
          if (w_wr_fire) begin
            r_addr   <= next_addr(r_addr);
            r_remain <= r_remain - REM_ONE;
            if (r_remain == REM_ONE) begin
              r_state     <= ST_IDLE;
              r_wr_ready  <= 1'b0;
              r_busy      <= 1'b0;
              r_cmd_ready <= 1'b1;
            end
          end
        end
        ST_READ: begin
          if (w_issue) begin
            r_addr     <= next_addr(r_addr);
            r_remain   <= r_remain - REM_ONE;
            r_rd_valid <= 1'b1;
          end else if (w_consume) begin
            r_rd_valid <= 1'b0;
            if (r_remain == '0) begin
              r_state     <= ST_IDLE;
              r_busy      <= 1'b0;
              r_cmd_ready <= 1'b1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.cmd_ready = r_cmd_ready;
  assign bus.wr_ready  = r_wr_ready;
  assign bus.rd_valid  = r_rd_valid;
  assign bus.rd_data   = w_rdata;
  assign bus.busy      = r_busy;
  assign bus.err       = r_err;

endmodule
